// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared pipeline widths, forwarding/FSM encodings and forward-select helper
package hazard_unit_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W = 16;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;
  // Youngest producer wins; x0 is hard-wired zero and never forwards
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] exm_rd,
    input logic exm_we,
    input logic [REG_ADDR_W-1:0] mwb_rd,
    input logic mwb_we
  );
    return (exm_we && exm_rd != '0 && exm_rd == rs) ? FWD_EXMEM :
           (mwb_we && mwb_rd != '0 && mwb_rd == rs) ? FWD_MEMWB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_unit_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and asynchronous reset
module sat_counter
  import hazard_unit_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  // Clear beats increment; count sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_inc && r_q != '1) r_q <= r_q + 1'b1;
  end
  assign o_q = r_q;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: operand forwarding, load-use stall and taken-branch flush control with perf counters
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1addr,
  input  logic [REG_ADDR_W-1:0] id_rs2addr,
  input  logic [REG_ADDR_W-1:0] id_ex_rs1addr,
  input  logic [REG_ADDR_W-1:0] id_ex_rs2addr,
  input  logic [REG_ADDR_W-1:0] id_ex_rdaddr,
  input  logic                  id_ex_memread,
  input  logic                  id_ex_regwrite,
  input  logic [REG_ADDR_W-1:0] ex_mem_rdaddr,
  input  logic                  ex_mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_wb_rdaddr,
  input  logic                  mem_wb_regwrite,
  input  logic                  branch_taken,
  input  logic                  cnt_clr,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  logic [0:0] r_state;
  logic w_lu, w_run, w_br, w_stall, w_fl, w_unused;
  assign w_unused = id_ex_regwrite;
  // Hazard decode; everything is gated off while reset is held so the pipeline free-runs
  always_comb begin
    w_lu = id_ex_memread && id_ex_rdaddr != '0 &&
           (id_ex_rdaddr == id_rs1addr || id_ex_rdaddr == id_rs2addr);
    w_run = !rst && r_state == ST_RUN;
    w_br = w_run && branch_taken;
    w_stall = w_run && !branch_taken && w_lu;
    w_fl = !rst && r_state == ST_FLUSH;
    pc_write_en = !w_stall;
    if_id_write_en = !w_stall;
    id_ex_bubble = w_br || w_stall || w_fl;
    if_id_flush = w_br;
    fwd_a = fwd_sel(id_ex_rs1addr, ex_mem_rdaddr, ex_mem_regwrite, mem_wb_rdaddr, mem_wb_regwrite);
    fwd_b = fwd_sel(id_ex_rs2addr, ex_mem_rdaddr, ex_mem_regwrite, mem_wb_rdaddr, mem_wb_regwrite);
  end
  // FLUSH lasts exactly one cycle after a taken branch, covering the wrong-path ID slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else r_state <= w_br ? ST_FLUSH : ST_RUN;
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .i_inc(w_stall), .i_clr(cnt_clr), .o_q(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .i_inc(w_br), .i_clr(cnt_clr), .o_q(flush_cnt)
  );
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL expose ports: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL expose: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL expose: id_rs1addr, id_rs2addr  input  5 each  decode-stage source register addresses.
REQ-004 SHALL expose: id_ex_rs1addr, id_ex_rs2addr, id_ex_rdaddr  input  5 each  ID/EX stage register addresses.
REQ-005 SHALL expose: id_ex_memread, id_ex_regwrite  input  1 each  ID/EX instruction is a load / writes rd.
REQ-006 SHALL expose: ex_mem_rdaddr  input  5; ex_mem_regwrite  input  1  EX/MEM destination and write-enable.
REQ-007 SHALL expose: mem_wb_rdaddr  input  5; mem_wb_regwrite  input  1  MEM/WB destination and write-enable.
REQ-008 SHALL expose: branch_taken  input  1  EX-stage branch/jump resolved taken; cnt_clr  input  1  synchronous counter clear.
REQ-009 SHALL expose: fwd_a, fwd_b  output  2 each  ALU operand source select (00 regfile, 01 MEM/WB, 10 EX/MEM).
REQ-010 SHALL expose: pc_write_en, if_id_write_en  output  1 each  hold PC / IF-ID when low.
REQ-011 SHALL expose: id_ex_bubble, if_id_flush  output  1 each  insert NOP into ID/EX / squash IF-ID.
REQ-012 SHALL expose: stall_cnt, flush_cnt  output  16 each  saturating performance counters.

Function
REQ-013 fwd_a SHALL be 10 when ex_mem_regwrite && ex_mem_rdaddr!=0 && ex_mem_rdaddr==id_ex_rs1addr; else 01 when the same holds for MEM/WB; else 00 (combinational, EX/MEM wins).
REQ-014 fwd_b SHALL follow REQ-013 using id_ex_rs2addr.
REQ-015 Load-use condition lu SHALL be id_ex_memread && id_ex_rdaddr!=0 && (id_ex_rdaddr==id_rs1addr || id_ex_rdaddr==id_rs2addr).
REQ-016 FSM SHALL have states RUN and FLUSH; reset state RUN.
REQ-017 In RUN with branch_taken=1: if_id_flush=1, id_ex_bubble=1, pc_write_en=1, if_id_write_en=1 same cycle; next state FLUSH; flush_cnt increments.
REQ-018 In RUN with branch_taken=0 and lu=1: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1 same cycle; state stays RUN; stall_cnt increments.
REQ-019 branch_taken SHALL take priority over lu in the same cycle (no stall, no stall_cnt increment).
REQ-020 In FLUSH: id_ex_bubble=1, if_id_flush=0, pc/if_id write enables 1; branch_taken and lu ignored (wrong-path); next state RUN unconditionally (exactly one cycle).
REQ-021 In RUN with neither event: pc_write_en=1, if_id_write_en=1, id_ex_bubble=0, if_id_flush=0.
REQ-022 Counters SHALL saturate at 16'hFFFF; cnt_clr=1 SHALL zero both on the next edge and override any increment that cycle.
REQ-023 Register x0 (address 0) SHALL never cause forwarding or stall.

Reset
REQ-024 rst=1 SHALL immediately force state RUN, stall_cnt=0, flush_cnt=0, independent of clk.
REQ-025 While rst=1 outputs SHALL be pc_write_en=1, if_id_write_en=1, id_ex_bubble=0, if_id_flush=0; fwd_a/fwd_b stay combinational.
REQ-026 Reset asserted in FLUSH SHALL abandon the pending bubble; first cycle after release is RUN.

Structure
REQ-027 Shared pipeline package SHALL hold REG_ADDR_W=5, FWD_RF/FWD_MEMWB/FWD_EXMEM encodings, FSM state encodings, CNT_W=16.
REQ-028 One sub-module sat_counter (CNT_W wide, inc, clr, async rst) SHALL be instantiated twice for stall_cnt and flush_cnt.

Verification
REQ-029 ex_mem rd=5 regwrite=1, mem_wb rd=5 regwrite=1, id_ex rs1=5 -> fwd_a=10; drop ex_mem_regwrite -> fwd_a=01; rd=0 both -> fwd_a=00.
REQ-030 id_ex memread=1 rd=7, id_rs2addr=7 -> one cycle pc_write_en=0, if_id_write_en=0, id_ex_bubble=1; stall_cnt 0->1.
REQ-031 branch_taken=1 with lu=1 same cycle -> if_id_flush=1, bubble=1, pc_write_en=1; next cycle FLUSH bubble=1; flush_cnt=1, stall_cnt=0.
REQ-032 branch_taken held 2 cycles -> second ignored in FLUSH; flush_cnt=1; RUN on cycle 3.
REQ-033 Preload stall_cnt to 16'hFFFE by 2 stalls short of wrap, stall 3 times -> holds 16'hFFFF; cnt_clr=1 -> 0.
REQ-034 rst asserted mid-cycle while in FLUSH -> state RUN, counters 0 before next clk edge; no bubble after release.
